// File: rtl/eth_pkg.sv
// Shared definitions for the CHDR Ethernet deframer: header constants, settings-bus
// register offsets, FSM state encoding and the running header-match flags.
package eth_pkg;

  localparam int unsigned ETH_HDR_WORDS  = 6;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

  // Settings register offsets from BASE.
  localparam logic [7:0] SR_MAC_HI = 8'd0;
  localparam logic [7:0] SR_MAC_LO = 8'd1;
  localparam logic [7:0] SR_IP     = 8'd2;
  localparam logic [7:0] SR_PORT   = 8'd3;

  typedef enum logic [1:0] {S_HDR, S_FWD, S_DROP} state_e;

  // The MAC compare spans two words, so unicast and broadcast hits are tracked
  // separately; every other field folds into rest.
  typedef struct packed {
    logic uni;
    logic bcast;
    logic rest;
  } match_t;

endpackage

// File: rtl/chdr_eth_deframer_if.sv
// 64-bit AXI-Stream bundle used on both sides of the deframer.
//   master: drives tdata/tuser/tlast/tvalid, receives tready.
//   slave : receives tdata/tuser/tlast/tvalid, drives tready.
// tuser[2:0] = valid bytes in last word (0 = 8), tuser[3] = error.
interface chdr_eth_deframer_if;
  logic [63:0] tdata;
  logic [3:0]  tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_hdr_matcher.sv
// Header field matcher. Given the index of the header word being accepted and its
// data, folds that word's field checks into the running match flags.
//   idx       : header word index 0..5
//   data      : header word
//   match_in  : flags accumulated over previous words (ignored at idx 0)
//   my_*      : programmed local addresses, enable
//   match_out : flags including this word
//   match     : complete verdict including this word
module eth_hdr_matcher
  import eth_pkg::*;
(
  input  logic [2:0]  idx,
  input  logic [63:0] data,
  input  match_t      match_in,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic [15:0] my_port,
  input  logic        enable,
  output match_t      match_out,
  output logic        match
);

  match_t base;

  always_comb begin
    // w0 starts a fresh frame, so prior flags are discarded.
    base           = (idx == 3'd0) ? '1 : match_in;
    match_out      = base;
    match_out.rest = base.rest & enable;
    case (idx)
      3'd0: begin
        match_out.uni   = base.uni & (data[15:0] == my_mac[47:32]);
        match_out.bcast = base.bcast & (data[15:0] == MAC_BCAST[47:32]);
      end
      3'd1: begin
        match_out.uni   = base.uni & (data[63:32] == my_mac[31:0]);
        match_out.bcast = base.bcast & (data[63:32] == MAC_BCAST[31:0]);
      end
      3'd2: match_out.rest = match_out.rest & (data[47:32] == ETHERTYPE_IPV4)
                                            & (data[31:24] == IP_VER_IHL);
      3'd3: match_out.rest = match_out.rest & (data[23:16] == IP_PROTO_UDP);
      3'd4: match_out.rest = match_out.rest & (data[31:0] == my_ip);
      3'd5: match_out.rest = match_out.rest & (data[47:32] == my_port);
      default: ;
    endcase
    match = (match_out.uni | match_out.bcast) & match_out.rest;
  end

endmodule

// File: rtl/chdr_eth_deframer.sv
// CHDR Ethernet deframer. Validates the 48-byte pad/Eth/IPv4/UDP header of each
// ingress frame against settings-bus programmed addresses, strips it and passes the
// CHDR payload through combinationally. Mismatching and runt frames are dropped whole.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : synchronous flush of the stream FSM
//   set_*        : settings bus (BASE+0..3: mac hi, mac lo, ip, {enable, port})
//   in_if        : ingress Ethernet frames
//   out_if       : egress CHDR payload
//   drop_count   : dropped-frame counter, wraps
module chdr_eth_deframer
  import eth_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  chdr_eth_deframer_if.slave          in_if,
  chdr_eth_deframer_if.master         out_if,
  output logic [31:0]                 drop_count
);

  logic [15:0] mac_hi_q;
  logic [31:0] mac_lo_q;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic        enable_q;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  match_t      match_q, match_d, match_out;
  logic        hdr_match;
  logic [31:0] drop_q, drop_d;
  logic        drop_inc;
  logic        live_q;
  logic        live;
  logic        in_ready;
  logic        accept;
  logic        unused_tuser;

  // Byte count and error flag are irrelevant here: errored frames are already gone.
  assign unused_tuser = ^in_if.tuser;

  // Settings registers, one per address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mac_hi_q <= '0;
      mac_lo_q <= '0;
      ip_q     <= '0;
      port_q   <= '0;
      enable_q <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == BASE + SR_MAC_HI) mac_hi_q <= set_data[15:0];
      if (set_addr == BASE + SR_MAC_LO) mac_lo_q <= set_data;
      if (set_addr == BASE + SR_IP)     ip_q     <= set_data;
      if (set_addr == BASE + SR_PORT) begin
        port_q   <= set_data[15:0];
        enable_q <= set_data[16];
      end
    end
  end

  eth_hdr_matcher u_matcher (
    .idx       (cnt_q),
    .data      (in_if.tdata),
    .match_in  (match_q),
    .my_mac    ({mac_hi_q, mac_lo_q}),
    .my_ip     (ip_q),
    .my_port   (port_q),
    .enable    (enable_q),
    .match_out (match_out),
    .match     (hdr_match)
  );

  // Stream is held off during reset and for one cycle after it.
  assign live   = reset_n & live_q;
  assign accept = in_if.tvalid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      match_q <= '0;
      drop_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      drop_q  <= drop_d;
      live_q  <= 1'b1;
    end
  end

  // Next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    drop_inc = 1'b0;
    case (state_q)
      S_HDR: begin
        if (accept) begin
          match_d = match_out;
          if (in_if.tlast) begin
            // Runt: frame ended inside the header.
            drop_inc = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == 3'(ETH_HDR_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = hdr_match ? S_FWD : S_DROP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_FWD: begin
        if (accept && in_if.tlast) state_d = S_HDR;
      end
      S_DROP: begin
        if (accept && in_if.tlast) begin
          drop_inc = 1'b1;
          state_d  = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
    if (clear) begin
      state_d  = S_HDR;
      cnt_d    = '0;
      drop_inc = 1'b0;
    end
    drop_d = drop_q + {31'd0, drop_inc};
  end

  // Outputs.
  always_comb begin
    in_ready      = 1'b0;
    out_if.tvalid = 1'b0;
    out_if.tdata  = '0;
    out_if.tlast  = 1'b0;
    out_if.tuser  = '0;
    if (live) begin
      case (state_q)
        S_FWD: begin
          out_if.tvalid = in_if.tvalid;
          out_if.tdata  = in_if.tdata;
          out_if.tlast  = in_if.tlast;
          in_ready      = out_if.tready;
        end
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign in_if.tready = in_ready;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_chdr_eth_deframer.sv
module tb_chdr_eth_deframer;

  localparam logic [47:0] MY_MAC = 48'h0080_2F11_2233;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] MY_IP  = 32'hC0A8_0A02;
  localparam logic [15:0] MY_PRT = 16'd49153;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] drop_count;

  chdr_eth_deframer_if in_if ();
  chdr_eth_deframer_if out_if ();

  chdr_eth_deframer #(.BASE(8'd0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .in_if      (in_if),
    .out_if     (out_if),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] frame_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] out_q[$];
  logic        mon_en = 1'b0;
  logic        mon_ready_low = 1'b0;

  // Collect every output handshake and watch in_tready when asked to.
  always @(negedge clk) begin
    if (out_if.tvalid && out_if.tready) out_q.push_back({out_if.tlast, out_if.tdata});
    if (mon_en && !in_if.tready) mon_ready_low = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic program_regs(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [15:0] port, input logic en);
    wr(8'd0, {16'h0, mac[47:32]});
    wr(8'd1, mac[31:0]);
    wr(8'd2, ip);
    wr(8'd3, {15'h0, en, port});
  endtask

  // Header + npay payload words into frame_q; payload word i is {tag, i}.
  task automatic build_frame(input logic [47:0] mac, input logic [15:0] etype,
                             input logic [7:0] proto, input logic [31:0] ip,
                             input logic [15:0] port, input int npay, input logic [31:0] tag);
    frame_q.delete();
    frame_q.push_back({48'h0000_0000_0000, mac[47:32]});
    frame_q.push_back({mac[31:0], 32'h0011_2233});
    frame_q.push_back({16'h4455, etype, 8'h45, 24'h000054});
    frame_q.push_back({40'h45_0000_5400, proto, 16'hBEEF});
    frame_q.push_back({32'hC0A8_0A01, ip});
    frame_q.push_back({16'h1234, port, 32'h0040_0000});
    for (int i = 0; i < npay; i++) frame_q.push_back({tag, 32'(i)});
  endtask

  task automatic expect_payload(input int npay, input logic [31:0] tag);
    for (int i = 0; i < npay; i++) exp_q.push_back({(i == npay - 1), tag, 32'(i)});
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    n = 0;
    in_if.tdata  = d;
    in_if.tlast  = last;
    in_if.tvalid = 1'b1;
    @(negedge clk);
    while (!in_if.tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_if.tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: in_tready=%0b after %0d cycles, required 1", in_if.tready, n);
    end
    tick();
  endtask

  task automatic send_words(input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send_beat(frame_q[i], last_at_end && (i == n - 1));
    if (last_at_end) begin
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    clear         = 1'b0;
    set_stb       = 1'b0;
    set_addr      = '0;
    set_data      = '0;
    in_if.tdata   = '0;
    in_if.tuser   = '0;
    in_if.tlast   = 1'b0;
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b1;
    repeat (2) tick();
    in_if.tvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %0b, required 0", in_if.tready);
    end
    n_checks++;
    if ({out_if.tvalid, out_if.tlast, out_if.tdata} !== 66'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%0b l=%0b d=%h, required all 0",
                         out_if.tvalid, out_if.tlast, out_if.tdata);
    end
    n_checks++;
    if (drop_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d, required 0", drop_count);
    end
    tick();
    reset_n      = 1'b1;
    in_if.tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_after_tready: got %0b, required 0", in_if.tready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (in_if.tready !== 1'b1) begin
      n_fail++; $display("FAIL live_tready: got %0b, required 1", in_if.tready);
    end
    tick();
  endtask

  task automatic test_match();
    program_regs(MY_MAC, MY_IP, MY_PRT, 1'b1);
    out_q.delete();
    exp_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 4, 32'hA000_0001);
    expect_payload(4, 32'hA000_0001);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 4) begin
      n_fail++; $display("FAIL match_count: got %0d words, required 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL match_word%0d: got %h, required %h", i, out_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (drop_count !== 32'd0) begin
      n_fail++; $display("FAIL match_drop: got %0d, required 0", drop_count);
    end
  endtask

  task automatic test_mismatch();
    out_q.delete();
    mon_ready_low = 1'b0;
    mon_en        = 1'b1;
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, 16'd49154, 3, 32'hA000_0002);
    send_words(frame_q.size(), 1'b1);
    build_frame(MY_MAC, 16'h86DD, 8'h11, MY_IP, MY_PRT, 3, 32'hA000_0003);
    send_words(frame_q.size(), 1'b1);
    mon_en = 1'b0;
    n_checks++;
    if (out_q.size() !== 0) begin
      n_fail++; $display("FAIL mismatch_emit: got %0d words, required 0", out_q.size());
    end
    n_checks++;
    if (drop_count !== 32'd2) begin
      n_fail++; $display("FAIL mismatch_drop: got %0d, required 2", drop_count);
    end
    n_checks++;
    if (mon_ready_low !== 1'b0) begin
      n_fail++; $display("FAIL mismatch_tready: low seen=%0b, required 0", mon_ready_low);
    end
  endtask

  task automatic test_bcast_enable();
    out_q.delete();
    exp_q.delete();
    build_frame(BCAST, 16'h0800, 8'h11, MY_IP, MY_PRT, 2, 32'hA000_0004);
    expect_payload(2, 32'hA000_0004);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 2) begin
      n_fail++; $display("FAIL bcast_count: got %0d words, required 2", out_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL bcast_word%0d: got %h, required %h", i, out_q[i], exp_q[i]);
        end
      end
    end
    program_regs(MY_MAC, MY_IP, MY_PRT, 1'b0);
    out_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 2, 32'hA000_0005);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 0 || drop_count !== 32'd3) begin
      n_fail++; $display("FAIL disabled_drop: got %0d words drop=%0d, required 0 words drop=3",
                         out_q.size(), drop_count);
    end
    program_regs(MY_MAC, MY_IP, MY_PRT, 1'b1);
  endtask

  task automatic test_runt();
    out_q.delete();
    exp_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 0, 32'h0);
    send_words(3, 1'b1);
    n_checks++;
    if (drop_count !== 32'd4) begin
      n_fail++; $display("FAIL runt3_drop: got %0d, required 4", drop_count);
    end
    send_words(6, 1'b1);
    n_checks++;
    if (drop_count !== 32'd5) begin
      n_fail++; $display("FAIL runt6_drop: got %0d, required 5", drop_count);
    end
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 5, 32'hA000_0006);
    expect_payload(5, 32'hA000_0006);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 5) begin
      n_fail++; $display("FAIL runt_next_count: got %0d words, required 5", out_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL runt_next_word%0d: got %h, required %h", i, out_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (drop_count !== 32'd5) begin
      n_fail++; $display("FAIL runt_next_drop: got %0d, required 5", drop_count);
    end
  endtask

  task automatic test_clear();
    out_q.delete();
    exp_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 0, 32'h0);
    send_words(3, 1'b0);
    in_if.tvalid = 1'b0;
    clear        = 1'b1;
    tick();
    clear = 1'b0;
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 2, 32'hA000_0007);
    expect_payload(2, 32'hA000_0007);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 2 || out_q[0] !== exp_q[0] || out_q[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL clear_fwd: got %0d words first=%h, required 2 words first=%h",
                         out_q.size(), (out_q.size() > 0) ? out_q[0] : 65'd0, exp_q[0]);
    end
    n_checks++;
    if (drop_count !== 32'd5) begin
      n_fail++; $display("FAIL clear_drop: got %0d, required 5", drop_count);
    end
  endtask

  task automatic test_random_backpressure();
    logic done;
    done = 1'b0;
    out_q.delete();
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          int len;
          len = $urandom_range(1, 180);
          build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, len, 32'hB000_0000 + 32'(k));
          expect_payload(len, 32'hB000_0000 + 32'(k));
          send_words(frame_q.size(), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          out_if.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_if.tready = 1'b1;
    n_checks++;
    if (out_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d words, required %0d", out_q.size(),
                         exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random_word%0d: got %h, required %h", i, out_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (drop_count !== 32'd5) begin
      n_fail++; $display("FAIL random_drop: got %0d, required 5", drop_count);
    end
  endtask

  task automatic test_reset_mid();
    out_q.delete();
    exp_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 6, 32'hC000_0001);
    send_words(8, 1'b0);
    in_if.tdata  = frame_q[8];
    in_if.tvalid = 1'b1;
    reset_n      = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_if.tready, out_if.tvalid, out_if.tlast, out_if.tdata} !== 67'd0) begin
      n_fail++; $display("FAIL midrst_out: got rdy=%0b v=%0b l=%0b d=%h, required all 0",
                         in_if.tready, out_if.tvalid, out_if.tlast, out_if.tdata);
    end
    tick();
    reset_n      = 1'b1;
    in_if.tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_if.tready, out_if.tvalid, out_if.tlast, out_if.tdata} !== 67'd0) begin
      n_fail++; $display("FAIL midrst_after: got rdy=%0b v=%0b l=%0b d=%h, required all 0",
                         in_if.tready, out_if.tvalid, out_if.tlast, out_if.tdata);
    end
    n_checks++;
    if (drop_count !== 32'd0) begin
      n_fail++; $display("FAIL midrst_drop: got %0d, required 0", drop_count);
    end
    tick();
    n_checks++;
    if (out_q.size() !== 2 || out_q[0] !== {1'b0, 32'hC000_0001, 32'd0}
        || out_q[1] !== {1'b0, 32'hC000_0001, 32'd1}) begin
      n_fail++; $display("FAIL midrst_partial: got %0d words, required 2 non-last", out_q.size());
    end
    // Settings were cleared, so a clean frame is now dropped.
    out_q.delete();
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 2, 32'hC000_0002);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 0 || drop_count !== 32'd1) begin
      n_fail++; $display("FAIL midrst_settings: got %0d words drop=%0d, required 0 words drop=1",
                         out_q.size(), drop_count);
    end
    program_regs(MY_MAC, MY_IP, MY_PRT, 1'b1);
    build_frame(MY_MAC, 16'h0800, 8'h11, MY_IP, MY_PRT, 3, 32'hC000_0003);
    expect_payload(3, 32'hC000_0003);
    send_words(frame_q.size(), 1'b1);
    n_checks++;
    if (out_q.size() !== 3) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d words, required 3", out_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL midrst_next_word%0d: got %h, required %h", i, out_q[i],
                             exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_bcast_enable();
    test_runt();
    test_clear();
    test_random_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
